ext_unit_pipe: RTL and testbench
================================

// Module: ext_unit_pipe
// PURPOSE
//  Parametrised, pipelined extension unit for the MIPS datapath. Successor to the combinational immediate extender.
//  Adds immediate modes (zero, sign, LUI) and load-data modes (LB/LBU/LH/LHU byte/half select + extend).
//  Adds a valid/ready handshake, a 2-entry output buffer and a flush, so it sits between the ID/EX and MEM/WB stages.
// PARAMETERS
//  IN_W   16  immediate width taken from DataIn[IN_W-1:0] in immediate modes
//  OUT_W  32  result/data width; must be a multiple of 8 and >= 2*IN_W
//  OFF_W  2   byte-offset width = log2(OUT_W/8)
// PORTS
//  CLK       in   1      clock, rising edge
//  Reset     in   1      asynchronous, active-low reset
//  Flush     in   1      synchronous: discard all buffered entries
//  InValid   in   1      input beat valid
//  InReady   out  1      unit can accept a beat
//  ExtOp     in   3      mode select (see BEHAVIOUR)
//  ByteOff   in   OFF_W  byte address offset (load modes only)
//  DataIn    in   OUT_W  immediate in low IN_W bits, or a raw memory word
//  OutValid  out  1      result valid
//  OutReady  in   1      consumer accepts result
//  ExtOut    out  OUT_W  extended result
//  ErrOut    out  1      result flagged: misaligned half or reserved op
// BEHAVIOUR
//  Reset (Reset=0, async): buffer empty; OutValid=0, InReady=1, ExtOut=0, ErrOut=0.
//  ExtOp encoding:
//   000 zero-extend imm
//   001 sign-extend imm (replicate DataIn[IN_W-1])
//   010 LUI: {imm, IN_W... zeros}, i.e. imm << (OUT_W-IN_W); upper bits beyond that are 0
//   011 LB: sign-extend byte DataIn[8*ByteOff +: 8]
//   100 LBU: zero-extend the same byte
//   101 LH: sign-extend half DataIn[8*ByteOff +: 16]
//   110 LHU: zero-extend the same half
//   111 reserved: ExtOut=0, ErrOut=1
//  LH/LHU misalignment: ByteOff[0]=1, or ByteOff+2 > OUT_W/8. Result is ExtOut=0, ErrOut=1.
//  Byte order is little-endian: ByteOff=0 selects bits [7:0].
//  Result is computed combinationally on accept and written into the buffer: latency 1 cycle.
//   Beat accepted at edge N gives OutValid=1 after edge N if the buffer was empty.
//  Buffer: 2-entry FIFO, count 0..2; ExtOut/ErrOut are driven from the head entry.
//   InReady = (count<2). Derived from registered count only; no combinational path from OutReady.
//   push = InValid & InReady; pop = OutValid & OutReady.
//   count 0 + push -> 1. count 1 + push & pop -> 1 (head replaced by new entry, order kept).
//   count 2 + pop -> 1; a push cannot occur at count 2.
//  When empty: OutValid=0 and ExtOut/ErrOut hold their last value. The bench checks them only when OutValid=1.
//  ExtOut, ErrOut and OutValid are stable while OutValid=1 & OutReady=0.
//  Flush=1 at an edge: count becomes 0 and OutValid=0. A push in the same cycle is dropped (flush wins).
//   InReady=1 on the next cycle.
//  Reset asserted mid-stream: buffer is cleared immediately. No partial result is ever presented.
//  Inputs are sampled only when push=1; ExtOp/ByteOff/DataIn are don't-care otherwise.
// TESTING
//  1 Sign: ExtOp=001, DataIn=0x0000_8001, OutReady=1 -> next cycle OutValid=1, ExtOut=0xFFFF_8001, ErrOut=0.
//  2 Zero/LUI: ExtOp=000, DataIn=0xABCD_8001 -> 0x0000_8001. ExtOp=010, DataIn=0x0000_1234 -> 0x1234_0000.
//  3 Loads: DataIn=0x80FF_7F01. LB off=2 -> 0xFFFF_FFFF. LBU off=3 -> 0x0000_0080. LH off=2 -> 0xFFFF_80FF.
//    LHU off=0 -> 0x0000_7F01. LH off=1 -> ExtOut=0, ErrOut=1. ExtOp=111 -> ErrOut=1.
//  4 Backpressure: OutReady=0, push A then B -> InReady=0 after 2nd accept, C is held off.
//    OutReady=1 -> A, B, C delivered in order, none lost or duplicated.
//  5 Flush: count=2, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, no stale output afterwards.
//  6 Async reset: drop Reset between edges with count=1 -> OutValid=0 immediately.
//    After release, first accepted beat appears 1 cycle later.

Source files
------------

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate / load-data extension unit with a valid/ready input,
// a 2-entry output FIFO and a synchronous flush.
//
// Ports:
//   CLK      - clock, rising edge
//   Reset    - asynchronous, active-low reset
//   Flush    - synchronous discard of all buffered entries
//   InValid  - input beat valid
//   InReady  - unit can accept a beat (registered, no path from OutReady)
//   ExtOp    - mode: 0 zext, 1 sext, 2 LUI, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 rsvd
//   ByteOff  - byte offset for load modes (little-endian)
//   DataIn   - immediate in low IN_W bits, or raw memory word
//   OutValid - head entry valid
//   OutReady - consumer accepts head entry
//   ExtOut   - extended result of head entry
//   ErrOut   - head entry flagged (misaligned half or reserved op)
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OFF_W = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ExtOp,
    input  logic [OFF_W-1:0] ByteOff,
    input  logic [OUT_W-1:0] DataIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] ExtOut,
    output logic             ErrOut
);

    localparam int NB = OUT_W / 8;

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] data;
    } entry_t;

    entry_t     e0_q, e0_d;
    entry_t     e1_q, e1_d;
    logic [1:0] count_q, count_d;

    entry_t            new_e;
    logic [IN_W-1:0]   imm;
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic              half_ok;
    logic              push;
    logic              pop;

    assign imm    = DataIn[IN_W-1:0];
    // Shift the addressed byte down to bit 0; the cast keeps only
    // the half-word window, so byte and half share one shifter.
    assign half_v = 16'(DataIn >> {ByteOff, 3'b000});
    assign byte_v = half_v[7:0];
    assign half_ok = !ByteOff[0] && (int'(ByteOff) + 2 <= NB);

    always_comb begin
        new_e = '0;
        unique case (ExtOp)
            3'b000: new_e.data = {{(OUT_W-IN_W){1'b0}}, imm};
            3'b001: new_e.data = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            3'b010: new_e.data = {imm, {(OUT_W-IN_W){1'b0}}};
            3'b011: new_e.data = {{(OUT_W-8){byte_v[7]}}, byte_v};
            3'b100: new_e.data = {{(OUT_W-8){1'b0}}, byte_v};
            3'b101: begin
                if (half_ok) new_e.data = {{(OUT_W-16){half_v[15]}}, half_v};
                else         new_e.err  = 1'b1;
            end
            3'b110: begin
                if (half_ok) new_e.data = {{(OUT_W-16){1'b0}}, half_v};
                else         new_e.err  = 1'b1;
            end
            default: new_e.err = 1'b1;
        endcase
    end

    assign InReady  = (count_q < 2'd2);
    assign OutValid = (count_q != 2'd0);
    assign ExtOut   = e0_q.data;
    assign ErrOut   = e0_q.err;

    assign push = InValid & InReady;
    assign pop  = OutValid & OutReady;

    // e0 is always the head; e1 only holds the second entry at count 2.
    // On pop-to-empty e0 is left alone so the outputs keep their value.
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (Flush) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        e0_d    = new_e;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0_d = new_e;
                    end else if (push) begin
                        e1_d    = new_e;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        e0_d    = e1_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: directed steps followed by
// randomized traffic checked against a queue-based reference model.
module tb_ext_unit_pipe;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [2:0]  ExtOp;
    logic [1:0]  ByteOff;
    logic [31:0] DataIn;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ExtOut;
    logic        ErrOut;

    int errors = 0;
    int checks = 0;

    logic [32:0] q[$];

    always #5 CLK = ~CLK;

    ext_unit_pipe dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .ExtOp    (ExtOp),
        .ByteOff  (ByteOff),
        .DataIn   (DataIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ExtOut   (ExtOut),
        .ErrOut   (ErrOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {err, data} from the mode rules with plain arithmetic.
    function automatic logic [32:0] ref_ext(input logic [2:0] op,
                                            input int off,
                                            input logic [31:0] d);
        logic [31:0] imm;
        logic [31:0] b;
        logic [31:0] h;
        imm = d & 32'h0000_FFFF;
        b   = (d >> (8 * off)) & 32'h0000_00FF;
        h   = (d >> (8 * off)) & 32'h0000_FFFF;
        case (op)
            3'd0: return {1'b0, imm};
            3'd1: return {1'b0, (imm >= 32'h8000) ? (imm | 32'hFFFF_0000) : imm};
            3'd2: return {1'b0, imm * 32'd65536};
            3'd3: return {1'b0, (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b};
            3'd4: return {1'b0, b};
            3'd5, 3'd6: begin
                if ((off % 2) != 0 || off + 2 > 4) return {1'b1, 32'h0};
                if (op == 3'd5 && h >= 32'h8000) return {1'b0, h | 32'hFFFF_0000};
                return {1'b0, h};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // One beat through an empty buffer with OutReady=1.
    task automatic beat(input string tag, input logic [2:0] op,
                        input logic [1:0] off, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
        InValid  = 1'b1;
        ExtOp    = op;
        ByteOff  = off;
        DataIn   = d;
        OutReady = 1'b1;
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        if (OutValid) begin
            chk({tag, "_data"}, ExtOut, exp_d);
            chk({tag, "_err"}, 32'(ErrOut), 32'(exp_e));
        end
        @(posedge CLK);
        #1;
        chk({tag, "_drain"}, 32'(OutValid), 32'd0);
    endtask

    initial begin
        logic        push;
        logic        pop;
        logic [32:0] exp;

        Reset    = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        ExtOp    = 3'd0;
        ByteOff  = 2'd0;
        DataIn   = 32'd0;
        OutReady = 1'b0;

        #12;
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_ready", 32'(InReady), 32'd1);
        chk("rst_data", ExtOut, 32'd0);
        chk("rst_err", 32'(ErrOut), 32'd0);
        #2 Reset = 1'b1;
        @(posedge CLK);
        #1;

        beat("sext", 3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
        beat("zext", 3'b000, 2'd0, 32'hABCD_8001, 32'h0000_8001, 1'b0);
        beat("lui", 3'b010, 2'd0, 32'h0000_1234, 32'h1234_0000, 1'b0);
        beat("lb2", 3'b011, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0);
        beat("lbu3", 3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0);
        beat("lh2", 3'b101, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
        beat("lhu0", 3'b110, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0);
        beat("lh1", 3'b101, 2'd1, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        beat("lhu3", 3'b110, 2'd3, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        beat("rsvd", 3'b111, 2'd0, 32'h1234_5678, 32'h0000_0000, 1'b1);

        // Backpressure: A, B fill the buffer, C is held off.
        OutReady = 1'b0;
        InValid  = 1'b1;
        ExtOp    = 3'b001;
        DataIn   = 32'h0000_F00F;
        @(posedge CLK);
        #1;
        chk("bp_a_valid", 32'(OutValid), 32'd1);
        chk("bp_a_ready", 32'(InReady), 32'd1);
        ExtOp  = 3'b000;
        DataIn = 32'h1234_5678;
        @(posedge CLK);
        #1;
        chk("bp_full", 32'(InReady), 32'd0);
        chk("bp_head_a", ExtOut, 32'hFFFF_F00F);
        ExtOp  = 3'b010;
        DataIn = 32'h0000_BEEF;
        @(posedge CLK);
        #1;
        chk("bp_hold_rdy", 32'(InReady), 32'd0);
        chk("bp_hold_vld", 32'(OutValid), 32'd1);
        chk("bp_hold_a", ExtOut, 32'hFFFF_F00F);
        OutReady = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_head_b", ExtOut, 32'h0000_5678);
        chk("bp_rdy_b", 32'(InReady), 32'd1);
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        chk("bp_vld_c", 32'(OutValid), 32'd1);
        chk("bp_head_c", ExtOut, 32'hBEEF_0000);
        @(posedge CLK);
        #1;
        chk("bp_empty", 32'(OutValid), 32'd0);

        // Flush at count 2 with InValid high.
        OutReady = 1'b0;
        InValid  = 1'b1;
        ExtOp    = 3'b000;
        DataIn   = 32'h0000_0011;
        repeat (2) @(posedge CLK);
        #1;
        chk("fl_full", 32'(InReady), 32'd0);
        Flush = 1'b1;
        @(posedge CLK);
        #1;
        chk("fl2_valid", 32'(OutValid), 32'd0);
        chk("fl2_ready", 32'(InReady), 32'd1);
        // Flush at count 1 while a push is possible: flush wins.
        Flush = 1'b0;
        @(posedge CLK);
        #1;
        Flush = 1'b1;
        @(posedge CLK);
        #1;
        Flush   = 1'b0;
        InValid = 1'b0;
        chk("fl1_valid", 32'(OutValid), 32'd0);
        @(posedge CLK);
        #1;
        chk("fl_stale", 32'(OutValid), 32'd0);

        // Asynchronous reset between edges with one entry buffered.
        InValid = 1'b1;
        ExtOp   = 3'b001;
        DataIn  = 32'h0000_FFFF;
        @(posedge CLK);
        #1;
        InValid = 1'b0;
        chk("ar_pre", 32'(OutValid), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("ar_valid", 32'(OutValid), 32'd0);
        chk("ar_ready", 32'(InReady), 32'd1);
        chk("ar_data", ExtOut, 32'd0);
        chk("ar_err", 32'(ErrOut), 32'd0);
        #1 Reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("ar_idle", 32'(OutValid), 32'd0);
        beat("ar_first", 3'b100, 2'd1, 32'h0000_A500, 32'h0000_00A5, 1'b0);

        // Randomized traffic against the queue model.
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = ($urandom_range(0, 3) != 0);
            Flush    = ($urandom_range(0, 39) == 0);
            ExtOp    = 3'($urandom);
            ByteOff  = 2'($urandom);
            DataIn   = $urandom;
            #1;
            chk("rnd_valid", 32'(OutValid), 32'(q.size() != 0));
            chk("rnd_ready", 32'(InReady), 32'(q.size() < 2));
            if (q.size() != 0 && OutValid) begin
                chk("rnd_data", ExtOut, q[0][31:0]);
                chk("rnd_err", 32'(ErrOut), 32'(q[0][32]));
            end
            push = InValid && (q.size() < 2);
            pop  = (q.size() != 0) && OutReady;
            exp  = ref_ext(ExtOp, int'(ByteOff), DataIn);
            @(posedge CLK);
            if (Flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(exp);
            end
            #1;
        end
        InValid = 1'b0;
        Flush   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
